// File: rtl/obstacle_map_reader.sv
// obstacle_map_reader: sweeps the obstacle generator's (x, y) query port
// across the play grid. Each row is packed into a bitmap and handed to a
// downstream consumer over a valid/ready handshake. At the end of the frame
// the number of obstacles found is checked against the obstacleCount value
// latched at start.
// Optional feature macro: OBSMAP_SKIP_EMPTY_EN. When it is defined, all-zero
// rows are never pushed to the consumer.
module obstacle_map_reader #(
  parameter int GRID_W = 14,
  parameter int GRID_H = 10
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              start,
  input  logic              s_reset,
  input  logic              obstacle,
  input  logic [3:0]        obstacleCount,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [GRID_W-1:0] row_data,
  output logic [3:0]        row_idx,
  output logic              row_valid,
  input  logic              row_ready,
  output logic              busy,
  output logic              done,
  output logic              mismatch
);

  localparam logic [3:0] LAST_X = 4'(GRID_W);
  localparam logic [3:0] LAST_Y = 4'(GRID_H);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    PUSH  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [7:0]          count;
  logic [3:0]          latched_count;
  logic [GRID_W-1:0]   row_next_s;
  logic                last_col_s;

  // Row bitmap including the column sampled this cycle
  always_comb begin
    row_next_s = row_data;
    if ((x != 4'd0) && (x <= LAST_X)) begin
      row_next_s[x - 4'd1] = obstacle;
    end else begin
      row_next_s = row_data;
    end
  end

  assign last_col_s = (x == LAST_X);

  // Scan sequencer: query sweep, row packing, handshake and the frame count check
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      x             <= 4'd0;
      y             <= 4'd0;
      row_data      <= '0;
      row_idx       <= 4'd0;
      row_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mismatch      <= 1'b0;
      count         <= 8'd0;
      latched_count <= 4'd0;
    end else if (s_reset) begin
      state     <= IDLE;
      x         <= 4'd0;
      y         <= 4'd0;
      row_data  <= '0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            latched_count <= obstacleCount;
            count         <= 8'd0;
            mismatch      <= 1'b0;
            row_data      <= '0;
            x             <= 4'd1;
            y             <= 4'd1;
            busy          <= 1'b1;
            state         <= SCAN;
          end else begin
            x    <= 4'd0;
            y    <= 4'd0;
            busy <= 1'b0;
          end
        end

        SCAN: begin
          row_data <= row_next_s;
          count    <= count + {7'd0, obstacle};
          if (!last_col_s) begin
            x <= x + 4'd1;
          end else begin
            x <= 4'd0;
`ifdef OBSMAP_SKIP_EMPTY_EN
            if (row_next_s == '0) begin
              // Empty row: advance straight past the push
              if (y == LAST_Y) begin
                y     <= 4'd0;
                state <= CHECK;
              end else begin
                y        <= y + 4'd1;
                x        <= 4'd1;
                row_data <= '0;
              end
            end else begin
              row_idx   <= y;
              row_valid <= 1'b1;
              state     <= PUSH;
            end
`else
            row_idx   <= y;
            row_valid <= 1'b1;
            state     <= PUSH;
`endif
          end
        end

        PUSH: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            if (y == LAST_Y) begin
              y     <= 4'd0;
              state <= CHECK;
            end else begin
              y        <= y + 4'd1;
              x        <= 4'd1;
              row_data <= '0;
              state    <= SCAN;
            end
          end else begin
            row_valid <= 1'b1;
          end
        end

        CHECK: begin
          mismatch <= (count != {4'b0000, latched_count});
          done     <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          x         <= 4'd0;
          y         <= 4'd0;
          row_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_map_reader.sv
// Self-checking bench for obstacle_map_reader. The generator is modelled as a
// combinational lookup into a bench-side map. The expected row stream and the
// count check are derived from that map.
module tb_obstacle_map_reader;

  localparam int W = 14;
  localparam int H = 10;
`ifdef OBSMAP_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nRst, start, s_reset, obstacle, row_ready;
  logic [3:0]    obstacleCount, x, y, row_idx;
  logic [W-1:0]  row_data;
  logic          row_valid, busy, done, mismatch;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] map [1:H];
  logic [W-1:0] seen [1:H];

  typedef struct { int idx; logic [W-1:0] data; } row_t;
  row_t exp_q[$];
  bit   frame_active = 1'b0;

  obstacle_map_reader #(.GRID_W(W), .GRID_H(H)) dut (
    .clk(clk), .nRst(nRst), .start(start), .s_reset(s_reset),
    .obstacle(obstacle), .obstacleCount(obstacleCount),
    .x(x), .y(y), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .row_ready(row_ready),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Generator model: combinational lookup, coordinate 0 masked
  always_comb begin
    obstacle = 1'b0;
    if (x >= 4'd1 && x <= 4'd14 && y >= 4'd1 && y <= 4'd10)
      obstacle = map[y][x - 4'd1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_map();
    for (int r = 1; r <= H; r++) map[r] = '0;
  endtask

  task automatic set_obs(input int c, input int r);
    map[r][c-1] = 1'b1;
  endtask

  // Model: the row stream the consumer must see, and the obstacle total
  task automatic build_expected(output int total);
    row_t e;
    exp_q.delete();
    total = 0;
    for (int r = 1; r <= H; r++) begin
      seen[r] = '0;
      for (int c = 0; c < W; c++) total += int'(map[r][c]);
      if (!SKIP || map[r] != '0) begin
        e.idx = r;
        e.data = map[r];
        exp_q.push_back(e);
      end
    end
  endtask

  // Compare process: row stream, stall stability and idle coordinates
  always @(negedge clk) begin
    #1;
    if (frame_active) begin
      if (row_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_row actual_idx=%0d required=none", row_idx);
        end else begin
          check("row_idx", row_idx, exp_q[0].idx);
          check("row_data", row_data, exp_q[0].data);
          check("push_x", x, 0);
          if (row_ready) begin
            if (row_idx >= 4'd1 && row_idx <= 4'd10) seen[row_idx] = row_data;
            void'(exp_q.pop_front());
          end
        end
      end
      if (!busy) begin
        check("idle_x", x, 0);
        check("idle_y", y, 0);
      end
    end
  end

  // Run one frame and check done timing, mismatch and completeness
  task automatic run_frame(input logic [3:0] cnt, input int stall_row, input int stall_n,
                           input int exp_done_n, input logic exp_mm, input int poke_n);
    int n, stalls_left, total;
    bit got;
    build_expected(total);
    obstacleCount = cnt;
    frame_active = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 0;
    got = 1'b0;
    stalls_left = stall_n;
    while (!got && n < 400) begin
      @(negedge clk);
      if (n == 0) begin
        check("start_mismatch_clear", mismatch, 0);
        check("start_busy", busy, 1);
        check("start_xy", {x, y}, 8'h11);
      end
      if (n == poke_n) begin
        start = 1'b1;
        obstacleCount = ~cnt;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        check("done_cycle", n + 1, exp_done_n + 1);
        check("mismatch", mismatch, exp_mm);
        check("mismatch_model", mismatch, (total != int'(cnt)));
      end
      if (row_valid && int'(row_idx) == stall_row && stalls_left > 0) begin
        row_ready = 1'b0;
        stalls_left--;
      end else begin
        row_ready = 1'b1;
      end
      @(posedge clk);
      n++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required_cycle=%0d", exp_done_n + 1);
    end
    start = 1'b0;
    row_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rows_remaining", exp_q.size(), 0);
    check("mismatch_held", mismatch, exp_mm);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    frame_active = 1'b0;
  endtask

  initial begin
    int n, dones;
    nRst = 1'b0; start = 1'b0; s_reset = 1'b0; row_ready = 1'b1;
    obstacleCount = 4'd0;
    clear_map();
    repeat (2) @(negedge clk);
    check("rst_xy", {x, y}, 0);
    check("rst_row", {row_data, row_idx}, 0);
    check("rst_flags", {row_valid, busy, done, mismatch}, 0);
    nRst = 1'b1;
    @(negedge clk);

    // 1: empty map
    run_frame(4'd0, -1, 0, SKIP ? 141 : 151, 1'b0, -1);

    // 2: three corner/centre obstacles, start and count poke while busy
    clear_map();
    set_obs(1, 1); set_obs(14, 10); set_obs(7, 5);
    run_frame(4'd3, -1, 0, SKIP ? 144 : 151, 1'b0, 20);
    check("row1_lit", seen[1], 14'h0001);
    check("row5_lit", seen[5], 14'h0040);
    check("row10_lit", seen[10], 14'h2000);

    // 3: backpressure, 5 stall cycles on a pushed row
    run_frame(4'd3, SKIP ? 5 : 3, 5, SKIP ? 149 : 156, 1'b0, -1);

    // 4: count mismatch, held in IDLE, cleared by next start
    clear_map();
    set_obs(2, 2); set_obs(9, 8);
    run_frame(4'd3, -1, 0, SKIP ? 143 : 151, 1'b1, -1);
    run_frame(4'd2, -1, 0, SKIP ? 143 : 151, 1'b0, -1);

    // 6: single obstacle
    clear_map();
    set_obs(3, 2);
    run_frame(4'd1, -1, 0, SKIP ? 142 : 151, 1'b0, -1);
    check("row2_lit", seen[2], 14'h0004);

    // 5a: s_reset in the 5th scan cycle of row 4
    @(negedge clk);
    obstacleCount = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && x == 4'd5 && y == 4'd4) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("sreset_reached", n < 300, 1);
    s_reset = 1'b1;
    @(posedge clk);
    #1;
    s_reset = 1'b0;
    check("sreset_xy", {x, y}, 0);
    check("sreset_flags", {row_valid, busy, done, mismatch}, 0);
    // start together with s_reset is ignored
    @(negedge clk);
    s_reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    s_reset = 1'b0;
    start = 1'b0;
    check("sreset_start_ignored", busy, 0);
    dones = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("sreset_no_done", dones, 0);

    // 5b: async nRst while a row is waiting in PUSH
    row_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!row_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_reached", row_valid, 1);
    #2;
    nRst = 1'b0;
    #1;
    check("arst_xy", {x, y}, 0);
    check("arst_row", {row_data, row_idx}, 0);
    check("arst_flags", {row_valid, busy, done, mismatch}, 0);
    @(negedge clk);
    nRst = 1'b1;
    row_ready = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
